// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a FIFO read port with one-cycle read latency and
// presents the words as a valid/ready stream framed into PKT_LEN-beat packets.
// A 3-entry buffer absorbs the read latency so the read strobe never depends
// on the downstream ready.
module fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PKT_LEN    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rempty,
    output logic                  o_rd,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_tlast,
    output logic [15:0]           o_pkt_cnt
);

    localparam int unsigned DEPTH  = 3;
    localparam int unsigned BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [1:0]            cnt;
    logic [1:0]            head;
    logic [1:0]            tail;
    logic                  inflight;
    logic [BEAT_W-1:0]     beat;
    logic                  wr;
    logic                  pop;
    logic                  beat_last;

    // Modulo-3 pointer increment.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign wr        = inflight;
    assign o_tvalid  = (cnt != 2'd0);
    assign o_tdata   = mem[head];
    assign beat_last = (beat == BEAT_LAST);
    assign o_tlast   = o_tvalid && beat_last;
    assign pop       = o_tvalid && i_tready;

    // Read issue: only from registered occupancy and the empty flag, so a
    // word in flight always has a free slot waiting for it.
    assign o_rd = !i_rst && !i_rempty && ((3'(cnt) + 3'(inflight)) < 3'(DEPTH));

    // Track the word requested last cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= o_rd;
        end
    end

    // Buffer storage: landing read data is written at tail.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr) begin
            mem[tail] <= i_rdata;
        end
    end

    // Pointers and occupancy; simultaneous write and pop leave cnt unchanged.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head <= 2'd0;
            tail <= 2'd0;
            cnt  <= 2'd0;
        end else begin
            if (wr) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            case ({wr, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Packet framing: beat position and completed-packet count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            beat      <= '0;
            o_pkt_cnt <= 16'd0;
        end else if (pop) begin
            if (beat_last) begin
                beat      <= '0;
                o_pkt_cnt <= o_pkt_cnt + 16'd1;
            end else begin
                beat <= beat + BEAT_W'(1);
            end
        end
    end

endmodule
